// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch stage.
//   PW, IW, OFFW : PC, instruction and relative-offset widths
//   HALT_OP      : instruction encoding that stops fetching
//   fetch_state_t: IDLE / RUN / HALTED
//   ABS_LUT      : absolute branch targets, indexed by lut_idx
//   REL_LUT      : two's-complement relative offsets, indexed by lut_idx
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int PW   = 16;
    localparam int IW   = 9;
    localparam int OFFW = 8;

    localparam logic [IW-1:0] HALT_OP = 9'b111_111_111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Packed tables: element [0] is the rightmost entry.
    // ABS_LUT[0..3] = 0x0000, 0x0008, 0x0010, 0x0020
    localparam logic [3:0][PW-1:0] ABS_LUT = {16'h0020, 16'h0010, 16'h0008, 16'h0000};
    // REL_LUT[0..3] = +2, -1, -3, +4
    localparam logic [3:0][OFFW-1:0] REL_LUT = {8'h04, 8'hFD, 8'hFF, 8'h02};

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Bundles the fetch stage's control, branch and ROM signals.
//   master : decode/ROM/testbench side (drives start, branches, inst)
//   slave  : fetch_unit side (drives PC, running, done)
// Optional macro FETCH_CYCLE_COUNT_EN adds cycle_count[31:0].
// ---------------------------------------------------------------------------
interface fetch_if;
    import fetch_pkg::*;

    logic            start;
    logic [PW-1:0]   start_addr;
    logic            stall;
    logic            br_abs;
    logic            br_rel;
    logic [1:0]      lut_idx;
    logic [IW-1:0]   inst;
    logic [PW-1:0]   PC;
    logic            running;
    logic            done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0]     cycle_count;

    modport master (
        output start, start_addr, stall, br_abs, br_rel, lut_idx, inst,
        input  PC, running, done, cycle_count
    );

    modport slave (
        input  start, start_addr, stall, br_abs, br_rel, lut_idx, inst,
        output PC, running, done, cycle_count
    );
`else
    modport master (
        output start, start_addr, stall, br_abs, br_rel, lut_idx, inst,
        input  PC, running, done
    );

    modport slave (
        input  start, start_addr, stall, br_abs, br_rel, lut_idx, inst,
        output PC, running, done
    );
`endif

endinterface

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
// Combinational lookup of branch targets from the package constants.
//   lut_idx    in  [1:0]   table index from decode
//   abs_target out [PW]    absolute branch target
//   rel_offset out [OFFW]  signed relative branch offset
// ---------------------------------------------------------------------------
module branch_lut
    import fetch_pkg::*;
(
    input  logic                   [1:0]  lut_idx,
    output logic                 [PW-1:0] abs_target,
    output logic signed        [OFFW-1:0] rel_offset
);

    assign abs_target = ABS_LUT[lut_idx];
    assign rel_offset = $signed(REL_LUT[lut_idx]);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Program counter and next-PC selection, upstream of a combinational ROM.
//   CLK      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of fetch_if:
//            start/start_addr, stall, br_abs/br_rel/lut_idx, inst in;
//            PC, running, done out
// Optional macro FETCH_CYCLE_COUNT_EN adds bus.cycle_count, a saturating
// count of cycles spent in RUN, cleared on every accepted start.
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
(
    input  logic    CLK,
    input  logic    reset_n,
    fetch_if.slave  bus
);

    // Sign-extend the offset to PC width and add; the carry is dropped so
    // the result wraps in both directions.
    function automatic logic [PW-1:0] sext_add(
        input logic        [PW-1:0]   base,
        input logic signed [OFFW-1:0] off
    );
        logic signed [PW-1:0] off_ext;
        off_ext  = PW'(off);
        sext_add = base + off_ext;
    endfunction

    fetch_state_t           state_p0, state_nxt;
    logic        [PW-1:0]   pc_p0, pc_nxt;
    logic                   running_p0, done_p0;

    logic        [PW-1:0]   abs_target;
    logic signed [OFFW-1:0] rel_offset;
    logic                   start_acc;

    branch_lut u_lut (
        .lut_idx    (bus.lut_idx),
        .abs_target (abs_target),
        .rel_offset (rel_offset)
    );

    // Next state / next PC. The halt check comes first so a halting
    // instruction leaves PC pointing at itself regardless of stall/branch.
    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        start_acc = 1'b0;
        unique case (state_p0)
            IDLE, HALTED: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_nxt = RUN;
                    pc_nxt    = bus.start_addr;
                end
            end
            RUN: begin
                if (bus.inst == HALT_OP) begin
                    state_nxt = HALTED;
                end else if (bus.stall) begin
                    pc_nxt = pc_p0;
                end else if (bus.br_abs) begin
                    pc_nxt = abs_target;
                end else if (bus.br_rel) begin
                    pc_nxt = sext_add(pc_p0, rel_offset);
                end else begin
                    pc_nxt = pc_p0 + PW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: state, PC and the registered status flags. The flags are
    // decoded from the next state so they come straight off flops.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_p0   <= IDLE;
            pc_p0      <= '0;
            running_p0 <= 1'b0;
            done_p0    <= 1'b0;
        end else begin
            state_p0   <= state_nxt;
            pc_p0      <= pc_nxt;
            running_p0 <= (state_nxt == RUN);
            done_p0    <= (state_nxt == HALTED);
        end
    end

    assign bus.PC      = pc_p0;
    assign bus.running = running_p0;
    assign bus.done    = done_p0;

`ifdef FETCH_CYCLE_COUNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] cnt_p0;

    // Counts every RUN cycle, including stalls and the halting fetch.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p0 <= '0;
        end else if (start_acc) begin
            cnt_p0 <= '0;
        end else if (state_p0 == RUN) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign bus.cycle_count = cnt_p0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic          start;
        logic [15:0]   addr;
        logic          stall;
        logic          br_abs;
        logic          br_rel;
        logic [1:0]    idx;
        logic [8:0]    inst;
        logic [15:0]   exp_pc;
        logic          exp_run;
        logic          exp_done;
        string         name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fetch_if bus ();

    fetch_unit dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] a, input logic st,
                         input logic ba, input logic br, input logic [1:0] ix,
                         input logic [8:0] in);
        @(negedge clk);
        bus.start      = s;
        bus.start_addr = a;
        bus.stall      = st;
        bus.br_abs     = ba;
        bus.br_rel     = br;
        bus.lut_idx    = ix;
        bus.inst       = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [15:0] pc,
                             input logic run, input logic dn);
        check({name, ".pc"},   {16'h0, bus.PC}, {16'h0, pc});
        check({name, ".run"},  {31'h0, bus.running}, {31'h0, run});
        check({name, ".done"}, {31'h0, bus.done}, {31'h0, dn});
    endtask

    vec_t vecs[20];

    initial begin
        checks   = 0;
        failures = 0;
        bus.start = 0; bus.start_addr = 0; bus.stall = 0;
        bus.br_abs = 0; bus.br_rel = 0; bus.lut_idx = 0; bus.inst = 0;

        //                 start addr     stl abs rel idx inst     pc       run done
        vecs[0]  = '{1, 16'h0005, 0, 0, 0, 0, 9'h000, 16'h0005, 1, 0, "start5"};
        vecs[1]  = '{0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0006, 1, 0, "seq6"};
        vecs[2]  = '{0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0007, 1, 0, "seq7"};
        vecs[3]  = '{0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0008, 1, 0, "seq8"};
        vecs[4]  = '{0, 16'h0000, 0, 0, 0, 0, HALT_OP, 16'h0008, 0, 1, "halt8"};
        vecs[5]  = '{1, 16'h0003, 0, 0, 0, 0, 9'h000, 16'h0003, 1, 0, "restart3"};
        vecs[6]  = '{0, 16'h0000, 0, 1, 0, 1, 9'h000, 16'h0008, 1, 0, "abs1"};
        vecs[7]  = '{0, 16'h0000, 0, 0, 1, 2, 9'h000, 16'h0005, 1, 0, "rel2"};
        vecs[8]  = '{0, 16'h0000, 0, 1, 1, 3, 9'h000, 16'h0020, 1, 0, "absrel3"};
        vecs[9]  = '{1, 16'h0100, 0, 0, 0, 0, 9'h000, 16'h0021, 1, 0, "start_in_run"};
        vecs[10] = '{0, 16'h0000, 0, 0, 1, 0, 9'h000, 16'h0023, 1, 0, "rel0"};
        vecs[11] = '{0, 16'h0000, 0, 0, 1, 3, 9'h000, 16'h0027, 1, 0, "rel3"};
        vecs[12] = '{0, 16'h0000, 0, 1, 0, 0, 9'h000, 16'h0000, 1, 0, "abs0"};
        vecs[13] = '{0, 16'h0000, 0, 0, 1, 1, 9'h000, 16'hFFFF, 1, 0, "rel_wrap_dn"};
        vecs[14] = '{0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 0, "inc_wrap"};
        vecs[15] = '{0, 16'h0000, 0, 1, 0, 2, 9'h000, 16'h0010, 1, 0, "abs2"};
        vecs[16] = '{0, 16'h0000, 1, 1, 0, 0, HALT_OP, 16'h0010, 0, 1, "halt_over_all"};
        vecs[17] = '{0, 16'h0000, 0, 1, 0, 1, 9'h000, 16'h0010, 0, 1, "halted_hold"};
        vecs[18] = '{1, 16'hFFFF, 0, 0, 0, 0, 9'h000, 16'hFFFF, 1, 0, "startFFFF"};
        vecs[19] = '{0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 0, "wrap0"};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 16'h1234, 0, 0, 0, 0, 9'h000);
        check_out("idle_hold", 16'h0000, 0, 0);

        // Asynchronous reset in the middle of a run
        drive(1, 16'h0040, 0, 0, 0, 0, 9'h000);
        drive(0, 16'h0000, 0, 0, 0, 0, 9'h000);
        check_out("pre_reset_run", 16'h0041, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven main sequence
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].start, vecs[i].addr, vecs[i].stall, vecs[i].br_abs,
                  vecs[i].br_rel, vecs[i].idx, vecs[i].inst);
            check_out(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_run, vecs[i].exp_done);
        end

        // Stall vs halt at PC=4, then restart to 2
        drive(0, 16'h0000, 0, 0, 0, 0, HALT_OP);
        check_out("halt0", 16'h0000, 0, 1);
        drive(1, 16'h0004, 0, 0, 0, 0, 9'h000);
        check_out("start4", 16'h0004, 1, 0);
        drive(0, 16'h0000, 1, 0, 0, 0, 9'h000);
        check_out("stall_a", 16'h0004, 1, 0);
        drive(0, 16'h0000, 1, 0, 1, 3, 9'h000);
        check_out("stall_b", 16'h0004, 1, 0);
        drive(0, 16'h0000, 1, 1, 0, 3, HALT_OP);
        check_out("halt_stall_abs", 16'h0004, 0, 1);
        drive(1, 16'h0002, 0, 0, 0, 0, 9'h000);
        check_out("restart2", 16'h0002, 1, 0);

`ifdef FETCH_CYCLE_COUNT_EN
        check("cnt_after_start", bus.cycle_count, 32'd0);
        drive(0, 16'h0000, 0, 0, 0, 0, 9'h000);
        drive(0, 16'h0000, 0, 0, 0, 0, 9'h000);
        drive(0, 16'h0000, 0, 0, 0, 0, 9'h000);
        check("cnt_run3", bus.cycle_count, 32'd3);
        drive(0, 16'h0000, 1, 0, 0, 0, 9'h000);
        check("cnt_stall", bus.cycle_count, 32'd4);
        drive(0, 16'h0000, 0, 0, 0, 0, HALT_OP);
        check("cnt_halt", bus.cycle_count, 32'd5);
        check_out("cnt_halted", 16'h0005, 0, 1);
        drive(0, 16'h0000, 0, 0, 0, 0, 9'h000);
        check("cnt_hold", bus.cycle_count, 32'd5);
        drive(1, 16'h0009, 0, 0, 0, 0, 9'h000);
        check("cnt_clear", bus.cycle_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
